seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//   Time-multiplexed scanner for the board's 8-digit hex display. Snapshots a 32-bit value
//   and presents one 4-bit nibble per scan slot, with the matching digit select, to the
//   per-digit BCD/hex segment path. Sits between the CPU debug/IO bus and the display pins.
//   Values are double-buffered, so the display never shows a mix of two values in one frame.
// PARAMETERS
//   SCAN_DIV    100000  clk cycles per digit slot (>=2); 100 MHz -> 1 kHz/digit
//   NUM_DIGITS  8       digits scanned (1..8); digit i shows nibble data[4i+3:4i]
// PORTS
//   clk         in   1   system clock, single clock domain
//   rst         in   1   synchronous reset, active-high
//   wr_data     in   32  new display value
//   wr_vld      in   1   wr_data valid this cycle
//   wr_rdy      out  1   1 = pending buffer free; write accepted when wr_vld & wr_rdy
//   seg_an      out  3   digit select, 0..NUM_DIGITS-1
//   seg_d       out  4   nibble for the selected digit (feeds the segment path)
//   seg_blank   out  1   1 = selected digit must be dark
//   frame_done  out  1   1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//   Reset: div_cnt=0, seg_an=0, shadow=0, pending empty, wr_rdy=1, seg_d=0,
//     seg_blank=0, frame_done=0. All outputs registered.
//   Prescaler: div_cnt counts 0..SCAN_DIV-1 and wraps. tick = (div_cnt==SCAN_DIV-1).
//   Digit index: on tick, seg_an <= (seg_an==NUM_DIGITS-1) ? 0 : seg_an+1.
//   frame_done: asserted in the cycle after the tick that wraps seg_an to 0.
//   Write handshake: wr_rdy = ~pend_full.
//     - wr_vld & wr_rdy: pend <= wr_data; pend_full <= 1.
//     - wr_vld & ~wr_rdy: write is ignored and not queued; the writer must hold wr_vld.
//   Frame swap: on the wrapping tick with pend_full=1: shadow <= pend; pend_full <= 0.
//     - Wrap tick and accepted write in the same cycle: the swap takes the OLD pend.
//       The new write is not lost; wr_rdy is 0 that cycle, so no accept happens.
//     - Write latency to display: at most one full frame plus one slot.
//   Output: seg_d <= shadow[4*idx_next +: 4], registered together with seg_an. seg_an and
//     seg_d always change in the same cycle; no glitch cycle with a mismatched pair.
//   Reset mid-frame: scan restarts at digit 0. A pending value is discarded.
//   NUM_DIGITS<8: upper nibbles are never selected; seg_an never exceeds NUM_DIGITS-1.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     - seg_blank=1 for digit i when all nibbles at positions >= i in shadow are 0.
//     - Digit 0 is never blanked, so a value of 0 displays as a single "0".
//   Not defined: seg_blank is tied to 0 and the blanking logic is absent.
// STRUCTURE
//   Package seg_pkg: SEG_MAX_DIGITS=8, SEG_IDX_W=3, typedef seg_nibble_t (4 bits).
//   Sub-module seg_scan_prescaler: divide counter with tick output; reused by other IO blocks.
//   Top-level holds the pending/shadow buffers, handshake, index register and output mux.
// TESTING
//   Use SCAN_DIV=4, NUM_DIGITS=8 unless stated otherwise.
//   1 Reset, then write 0x89ABCDEF. After the first frame wrap, seg_an steps 0..7 every
//     4 clk while seg_d shows F,E,D,C,B,A,9,8.
//   2 Mid-frame write 0x11111111, then wr_vld held with 0x22222222:
//     - Second write is stalled (wr_rdy=0) until the wrap.
//     - Next frame shows all 1s; the frame after shows all 2s.
//   3 wr_vld asserted in exactly the wrap-tick cycle with pend full: shadow gets the old
//     pend; the new data is accepted the next cycle.
//   4 Assert rst when seg_an=5: next cycle seg_an=0, seg_d=0, wr_rdy=1, div_cnt=0, and no
//     frame_done pulse.
//   5 frame_done pulses once every 32 clk, one cycle wide.
//   6 With LEADING_ZERO_BLANK_EN and value 0x00000A05:
//     - seg_blank=0 on digits 0..2, 1 on digits 3..7.
//     - Value 0: only digit 0 is unblanked.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, nibble type and nibble select for the hex display scanner
package seg_pkg;
   localparam int SEG_MAX_DIGITS = 8;
   localparam int SEG_IDX_W      = 3;

   typedef logic [3:0] seg_nibble_t;

   function automatic seg_nibble_t seg_nibble_at(input logic [4*SEG_MAX_DIGITS-1:0] value,
                                                 input logic [SEG_IDX_W-1:0] idx);
      return value[{idx, 2'b00} +: 4];
   endfunction
endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - write handshake and scan outputs of the display scanner
interface seg_scan_driver_if;
   import seg_pkg::*;

   logic [31:0]          wr_data;
   logic                 wr_vld;
   logic                 wr_rdy;
   logic [SEG_IDX_W-1:0] seg_an;
   seg_nibble_t          seg_d;
   logic                 seg_blank;
   logic                 frame_done;

   modport master (output wr_data, wr_vld,
                   input  wr_rdy, seg_an, seg_d, seg_blank, frame_done);
   modport slave  (input  wr_data, wr_vld,
                   output wr_rdy, seg_an, seg_d, seg_blank, frame_done);
endinterface

// File: rtl/seg_scan_prescaler.sv
// rtl/seg_scan_prescaler.sv - free-running divide-by-DIV counter with a one-cycle tick
module seg_scan_prescaler #(
   parameter int DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] div_cnt;

   assign tick = (div_cnt == CNT_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + CNT_W'(1);
   end
endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - double-buffered 8-digit hex scan driver
// Optional leading-zero blanking: LEADING_ZERO_BLANK_EN
module seg_scan_driver import seg_pkg::*; #(
   parameter int SCAN_DIV   = 100000,
   parameter int NUM_DIGITS = 8
) (
   input logic              clk,
   input logic              rst,
   seg_scan_driver_if.slave bus
);
   localparam logic [SEG_IDX_W-1:0] LAST_IDX = SEG_IDX_W'(NUM_DIGITS - 1);

   logic                 tick;
   logic                 wrap;
   logic                 swap;
   logic                 accept;
   logic [SEG_IDX_W-1:0] idx;
   logic [SEG_IDX_W-1:0] idx_next;
   logic [31:0]          pend;
   logic [31:0]          shadow;
   logic [31:0]          shadow_next;
   logic                 pend_full;
   seg_nibble_t          seg_d_q;
   logic                 frame_done_q;

   seg_scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // The swap happens on the same edge the index returns to 0, so digit 0 of the
   // new frame is taken from the value being loaded, never from the old one.
   always_comb begin
      wrap     = tick && (idx == LAST_IDX);
      idx_next = idx;
      if (tick)
         idx_next = wrap ? '0 : idx + SEG_IDX_W'(1);
      swap        = wrap && pend_full;
      shadow_next = swap ? pend : shadow;
      accept      = bus.wr_vld && !pend_full;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx          <= '0;
         seg_d_q      <= '0;
         frame_done_q <= 1'b0;
         shadow       <= '0;
         pend         <= '0;
         pend_full    <= 1'b0;
      end else begin
         if (tick) begin
            idx     <= idx_next;
            seg_d_q <= seg_nibble_at(shadow_next, idx_next);
         end
         frame_done_q <= wrap;
         shadow       <= shadow_next;
         if (swap) begin
            pend_full <= 1'b0;
         end else if (accept) begin
            pend      <= bus.wr_data;
            pend_full <= 1'b1;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic blank_q;
   logic blank_next;

   always_comb begin
      blank_next = (idx_next != '0) && ((shadow_next >> {idx_next, 2'b00}) == 32'd0);
   end

   always_ff @(posedge clk) begin
      if (rst)
         blank_q <= 1'b0;
      else if (tick)
         blank_q <= blank_next;
   end

   assign bus.seg_blank = blank_q;
`else
   assign bus.seg_blank = 1'b0;
`endif

   assign bus.wr_rdy     = !pend_full;
   assign bus.seg_an     = idx;
   assign bus.seg_d      = seg_d_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized self-checking bench for seg_scan_driver
module tb_seg_scan_driver;
   localparam int SCAN_DIV = 4;
   localparam int ND       = 8;
   localparam int FRAME    = SCAN_DIV * ND;

   logic clk = 1'b0;
   logic rst;
   seg_scan_driver_if bus();

   seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(ND)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: cycles since reset, one pending slot and the shown value
   int          n;
   logic [31:0] m_shadow;
   logic [31:0] m_pend;
   bit          m_full;

   function automatic int exp_an();
      return (n / SCAN_DIV) % ND;
   endfunction

   function automatic logic [3:0] exp_d();
      logic [31:0] v;
      v = m_shadow >> (4 * exp_an());
      return v[3:0];
   endfunction

   function automatic logic exp_fd();
      return (n > 0) && (n % FRAME == 0);
   endfunction

   function automatic logic exp_blank();
`ifdef LEADING_ZERO_BLANK_EN
      return (exp_an() != 0) && ((m_shadow >> (4 * exp_an())) == 32'd0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic step();
      bit          acc;
      bit          r;
      logic [31:0] d;
      acc = (bus.wr_vld === 1'b1) && !m_full;
      d   = bus.wr_data;
      r   = rst;
      @(posedge clk);
      if (r) begin
         n = 0; m_full = 0; m_pend = '0; m_shadow = '0;
      end else begin
         n++;
         if (n % FRAME == 0 && m_full) begin
            m_shadow = m_pend;
            m_full   = 0;
         end else if (acc) begin
            m_pend = d;
            m_full = 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic advance_to_phase(input int p);
      step();
      for (int k = 0; k < 2 * FRAME; k++) begin
         if (n % FRAME == p) break;
         step();
      end
   endtask

   task automatic write_value(input logic [31:0] v);
      bus.wr_data = v;
      bus.wr_vld  = 1'b1;
      for (int k = 0; k < 3 * FRAME; k++) begin
         if (bus.wr_rdy === 1'b1) break;
         step();
      end
      step();
      bus.wr_vld = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; if (bus.seg_an !== 3'd0) begin errors++; $display("FAIL reset_an: got %0d want 0", bus.seg_an); end
      checks++; if (bus.seg_d !== 4'd0) begin errors++; $display("FAIL reset_d: got %h want 0", bus.seg_d); end
      checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", bus.wr_rdy); end
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
      checks++; if (bus.seg_blank !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b want 0", bus.seg_blank); end
      rst = 1'b0;
   endtask

   task automatic test_digit_order();
      logic [3:0] tab [8];
      tab = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
      bus.wr_data = 32'h89ABCDEF;
      bus.wr_vld  = 1'b1;
      step();
      bus.wr_vld = 1'b0;
      checks++; if (bus.wr_rdy !== 1'b0) begin errors++; $display("FAIL order_pend_full: got %b want 0", bus.wr_rdy); end
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         if (n >= FRAME && n < 2 * FRAME) begin
            checks++;
            if (bus.seg_an !== 3'((n - FRAME) / SCAN_DIV)) begin
               errors++; $display("FAIL order_an n=%0d: got %0d want %0d", n, bus.seg_an, (n - FRAME) / SCAN_DIV);
            end
            checks++;
            if (bus.seg_d !== tab[(n - FRAME) / SCAN_DIV]) begin
               errors++; $display("FAIL order_d n=%0d: got %h want %h", n, bus.seg_d, tab[(n - FRAME) / SCAN_DIV]);
            end
         end
      end
      checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL order_rdy_after_swap: got %b want 1", bus.wr_rdy); end
   endtask

   task automatic test_stall();
      bit done;
      done = 0;
      advance_to_phase(10);
      bus.wr_data = 32'h11111111;
      bus.wr_vld  = 1'b1;
      step();
      bus.wr_data = 32'h22222222;
      for (int k = 0; k < 2 * FRAME; k++) begin
         checks++;
         if (bus.wr_rdy !== (n % FRAME == 0)) begin
            errors++; $display("FAIL stall_rdy n=%0d: got %b want %b", n, bus.wr_rdy, (n % FRAME == 0));
         end
         if (bus.wr_rdy === 1'b1) begin
            step();
            done = 1;
            break;
         end
         step();
      end
      bus.wr_vld = 1'b0;
      checks++; if (!done) begin errors++; $display("FAIL stall_timeout: got 0 accepts want 1"); end
      for (int k = 0; k < FRAME; k++) begin
         if (n % FRAME == 0) break;
         checks++;
         if (bus.seg_d !== 4'h1) begin errors++; $display("FAIL stall_ones n=%0d: got %h want 1", n, bus.seg_d); end
         step();
      end
      for (int k = 0; k < FRAME; k++) begin
         checks++;
         if (bus.seg_d !== 4'h2) begin errors++; $display("FAIL stall_twos n=%0d: got %h want 2", n, bus.seg_d); end
         step();
      end
   endtask

   task automatic test_wrap_collision();
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      advance_to_phase(5);
      bus.wr_data = a;
      bus.wr_vld  = 1'b1;
      step();
      bus.wr_vld = 1'b0;
      advance_to_phase(FRAME - 1);
      bus.wr_data = b;
      bus.wr_vld  = 1'b1;
      checks++; if (bus.wr_rdy !== 1'b0) begin errors++; $display("FAIL coll_busy: got %b want 0", bus.wr_rdy); end
      step();
      checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL coll_free: got %b want 1", bus.wr_rdy); end
      checks++; if (bus.seg_d !== a[3:0]) begin errors++; $display("FAIL coll_old: got %h want %h", bus.seg_d, a[3:0]); end
      step();
      bus.wr_vld = 1'b0;
      checks++; if (bus.wr_rdy !== 1'b0) begin errors++; $display("FAIL coll_accept: got %b want 0", bus.wr_rdy); end
      advance_to_phase(0);
      checks++; if (bus.seg_d !== b[3:0]) begin errors++; $display("FAIL coll_new: got %h want %h", bus.seg_d, b[3:0]); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (bus.wr_vld !== 1'b1 || bus.wr_rdy === 1'b1) begin
            bus.wr_vld  = ($urandom_range(0, 9) < 3);
            bus.wr_data = ($urandom_range(0, 3) == 0) ? 32'h0000_0000 + $urandom_range(0, 255) : $urandom;
         end
         step();
         checks++; if (bus.seg_an !== 3'(exp_an())) begin errors++; $display("FAIL rnd_an n=%0d: got %0d want %0d", n, bus.seg_an, exp_an()); end
         checks++; if (bus.seg_d !== exp_d()) begin errors++; $display("FAIL rnd_d n=%0d: got %h want %h", n, bus.seg_d, exp_d()); end
         checks++; if (bus.wr_rdy !== !m_full) begin errors++; $display("FAIL rnd_rdy n=%0d: got %b want %b", n, bus.wr_rdy, !m_full); end
         checks++; if (bus.frame_done !== exp_fd()) begin errors++; $display("FAIL rnd_fd n=%0d: got %b want %b", n, bus.frame_done, exp_fd()); end
         checks++; if (bus.seg_blank !== exp_blank()) begin errors++; $display("FAIL rnd_blank n=%0d: got %b want %b", n, bus.seg_blank, exp_blank()); end
      end
      bus.wr_vld = 1'b0;
   endtask

   task automatic test_reset_mid();
      if (!m_full) begin
         bus.wr_data = $urandom;
         bus.wr_vld  = 1'b1;
         step();
         bus.wr_vld = 1'b0;
      end
      for (int k = 0; k < 2 * FRAME; k++) begin
         if (exp_an() == 5) break;
         step();
      end
      checks++; if (bus.seg_an !== 3'd5) begin errors++; $display("FAIL rmid_pre_an: got %0d want 5", bus.seg_an); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (bus.seg_an !== 3'd0) begin errors++; $display("FAIL rmid_an: got %0d want 0", bus.seg_an); end
      checks++; if (bus.seg_d !== 4'd0) begin errors++; $display("FAIL rmid_d: got %h want 0", bus.seg_d); end
      checks++; if (bus.wr_rdy !== 1'b1) begin errors++; $display("FAIL rmid_rdy: got %b want 1", bus.wr_rdy); end
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rmid_fd: got %b want 0", bus.frame_done); end
      for (int k = 1; k <= 2 * SCAN_DIV; k++) begin
         step();
         checks++;
         if (bus.seg_an !== 3'(k / SCAN_DIV)) begin errors++; $display("FAIL rmid_restart k=%0d: got %0d want %0d", k, bus.seg_an, k / SCAN_DIV); end
      end
   endtask

   task automatic test_frame_done();
      int pulses;
      int last;
      pulses = 0;
      last   = -1;
      for (int k = 0; k < 3 * FRAME; k++) begin
         step();
         checks++;
         if (bus.frame_done !== exp_fd()) begin errors++; $display("FAIL fd_cycle n=%0d: got %b want %b", n, bus.frame_done, exp_fd()); end
         if (bus.frame_done === 1'b1) begin
            if (last >= 0) begin
               checks++;
               if (n - last != FRAME) begin errors++; $display("FAIL fd_period: got %0d want %0d", n - last, FRAME); end
            end
            pulses++;
            last = n;
         end
      end
      checks++; if (pulses != 3) begin errors++; $display("FAIL fd_count: got %0d want 3", pulses); end
   endtask

   task automatic test_blank();
      logic [31:0] vals [2];
      vals = '{32'h00000A05, 32'h00000000};
      for (int v = 0; v < 2; v++) begin
         write_value(vals[v]);
         advance_to_phase(0);
         for (int k = 0; k < FRAME; k++) begin
            int  dig;
            bit  want;
            dig = (n % FRAME) / SCAN_DIV;
`ifdef LEADING_ZERO_BLANK_EN
            want = (v == 0) ? (dig >= 3) : (dig != 0);
`else
            want = 1'b0;
`endif
            checks++;
            if (bus.seg_blank !== want) begin errors++; $display("FAIL blank v=%h dig=%0d: got %b want %b", vals[v], dig, bus.seg_blank, want); end
            step();
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.wr_vld  = 1'b0;
      bus.wr_data = '0;
      n = 0; m_full = 0; m_pend = '0; m_shadow = '0;
      test_reset();
      test_digit_order();
      test_stall();
      test_wrap_collision();
      test_random();
      test_reset_mid();
      test_frame_done();
      test_blank();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
